// File: rtl/host_cfg_sequencer_pkg.sv
// rtl/host_cfg_sequencer_pkg.sv - shared command-bus layout, opcodes and sequencer states
package host_cfg_sequencer_pkg;

    localparam int H_C_W      = 60;
    localparam int RUN_SPM_B  = 59;
    localparam int RUN_PE_HI  = 58;
    localparam int RUN_PE_LO  = 54;
    localparam int INIT_SPM_B = 53;
    localparam int INIT_PE_HI = 52;
    localparam int INIT_PE_LO = 48;
    localparam int PE_INST    = 48;

    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_INIT_SPM = 4'd1;
    localparam logic [3:0] OP_INIT_PE  = 4'd2;
    localparam logic [3:0] OP_RUN      = 4'd3;
    localparam logic [3:0] OP_WAIT     = 4'd4;
    localparam logic [3:0] OP_END      = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RUN,
        ST_WAIT
    } seq_state_t;

    function automatic logic [H_C_W-1:0] pack_hc(
        input logic               run_spm,
        input logic [4:0]         run_pe,
        input logic               init_spm,
        input logic [4:0]         init_pe,
        input logic [PE_INST-1:0] inst
    );
        logic [H_C_W-1:0] hc;
        hc                         = '0;
        hc[RUN_SPM_B]              = run_spm;
        hc[RUN_PE_HI:RUN_PE_LO]    = run_pe;
        hc[INIT_SPM_B]             = init_spm;
        hc[INIT_PE_HI:INIT_PE_LO]  = init_pe;
        hc[PE_INST-1:0]            = inst;
        return hc;
    endfunction

endpackage

// File: rtl/host_cfg_sequencer_cfg_cmd_fifo.sv
// rtl/host_cfg_sequencer_cfg_cmd_fifo.sv - show-ahead synchronous command FIFO with flush
module cfg_cmd_fifo
    import host_cfg_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/host_cfg_sequencer.sv
// rtl/host_cfg_sequencer.sv - buffers host command words and sequences them onto host_controller
module host_cfg_sequencer
    import host_cfg_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_data,
    output logic [H_C_W-1:0] host_controller,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [63:0]      head;
    logic             pop;

    logic [3:0]       opcode;
    logic [11:0]      aux;
    logic [47:0]      payload;
    logic [CNT_W-1:0] n_cycles;
    logic [5:0]       unused_aux;

    seq_state_t       dec_state;
    logic [H_C_W-1:0] dec_hc;
    logic [CNT_W-1:0] dec_cnt;
    logic             dec_done;
    logic             dec_err;

    assign cmd_ready  = !fifo_full;
    assign opcode     = head[63:60];
    assign aux        = head[59:48];
    assign payload    = head[47:0];
    assign n_cycles   = payload[CNT_W-1:0];
    assign unused_aux = aux[11:6];

    // The next command may pop in the final RUN/WAIT cycle so windows abut without a bubble.
    assign pop = !abort && !fifo_empty &&
                 ((state == ST_EXEC) ||
                  (((state == ST_RUN) || (state == ST_WAIT)) && (cnt == '0)));

    cfg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (cmd_valid && !abort),
        .wdata (cmd_data),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_comb begin
        dec_state = ST_EXEC;
        dec_hc    = '0;
        dec_cnt   = '0;
        dec_done  = 1'b0;
        dec_err   = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_INIT_SPM: dec_hc = pack_hc(1'b0, 5'd0, 1'b1, 5'd0, payload);
            OP_INIT_PE:  dec_hc = pack_hc(1'b0, 5'd0, 1'b0, aux[4:0], payload);
            OP_RUN: begin
                if (n_cycles != '0) begin
                    dec_hc    = pack_hc(aux[5], aux[4:0], 1'b0, 5'd0, '0);
                    dec_state = ST_RUN;
                    dec_cnt   = n_cycles - CNT_W'(1);
                end
            end
            OP_WAIT: begin
                if (n_cycles != '0) begin
                    dec_state = ST_WAIT;
                    dec_cnt   = n_cycles - CNT_W'(1);
                end
            end
            OP_END: begin
                dec_state = ST_IDLE;
                dec_done  = 1'b1;
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            host_controller <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else if (abort) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            host_controller <= '0;
            busy            <= 1'b0;
        end else if (pop) begin
            state           <= dec_state;
            cnt             <= dec_cnt;
            host_controller <= dec_hc;
            busy            <= (dec_state != ST_IDLE);
            if (dec_done) done <= 1'b1;
            if (dec_err)  err  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    host_controller <= '0;
                    if (start) begin
                        state <= ST_EXEC;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ST_EXEC: host_controller <= '0;
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state           <= ST_EXEC;
                        host_controller <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cfg_sequencer.sv
// tb/tb_host_cfg_sequencer.sv - self-checking bench for host_cfg_sequencer
module tb_host_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic [59:0] host_controller;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] cmd_q[$];
    logic [59:0] exp_q[$];
    logic        exp_err;

    always #5 clk = ~clk;

    host_cfg_sequencer #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .host_controller (host_controller),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [11:0] aux, input logic [47:0] pl);
        return {op, aux, pl};
    endfunction

    function automatic logic [59:0] hc_init_spm(input logic [47:0] pl);
        return {6'b0, 1'b1, 5'b0, pl};
    endfunction

    function automatic logic [59:0] hc_init_pe(input logic [4:0] pe, input logic [47:0] pl);
        return {6'b0, 1'b0, pe, pl};
    endfunction

    function automatic logic [59:0] hc_run(input logic spm, input logic [4:0] pe);
        return {spm, pe, 6'b0, 48'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        for (int k = 0; k < 400; k++) begin
            ok = cmd_ready;
            step();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout word=%h cmd_ready never high", w);
        end
    endtask

    // Expected per-cycle bus trace from the command list, built straight from the opcode rules.
    task automatic build_model();
        logic [3:0]  op;
        logic [11:0] aux;
        logic [47:0] pl;
        int          n;
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < cmd_q.size(); i++) begin
            op  = cmd_q[i][63:60];
            aux = cmd_q[i][59:48];
            pl  = cmd_q[i][47:0];
            n   = int'(pl % 48'h10000);
            case (op)
                4'd0: exp_q.push_back(60'b0);
                4'd1: exp_q.push_back(hc_init_spm(pl));
                4'd2: exp_q.push_back(hc_init_pe(aux[4:0], pl));
                4'd3: begin
                    if (n == 0) exp_q.push_back(60'b0);
                    for (int c = 0; c < n; c++) exp_q.push_back(hc_run(aux[5], aux[4:0]));
                end
                4'd4: begin
                    if (n == 0) exp_q.push_back(60'b0);
                    for (int c = 0; c < n; c++) exp_q.push_back(60'b0);
                end
                4'd5: begin
                    exp_q.push_back(60'b0);
                    break;
                end
                default: begin
                    exp_q.push_back(60'b0);
                    exp_err = 1'b1;
                end
            endcase
        end
    endtask

    // Preloads up to four words, then keeps feeding while the trace is checked cycle by cycle.
    task automatic run_program(input string name);
        int pre;
        build_model();
        pre = (cmd_q.size() < 4) ? cmd_q.size() : 4;
        for (int i = 0; i < pre; i++) push_word(cmd_q[i]);
        fork
            begin
                for (int i = 4; i < cmd_q.size(); i++) push_word(cmd_q[i]);
            end
            begin
                start = 1'b1;
                step();
                start = 1'b0;
                n_checks++;
                if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s start_flags got done=%b err=%b busy=%b want 0 0 1", name, done, err, busy);
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    step();
                    n_checks++;
                    if (host_controller !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL %s cycle %0d host_controller got %h want %h", name, i, host_controller, exp_q[i]);
                    end
                end
            end
        join
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== exp_err) begin
            n_fail++;
            $display("FAIL %s end_flags got done=%b busy=%b err=%b want 1 0 %b", name, done, busy, err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (host_controller !== 60'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got hc=%h ready=%b busy=%b done=%b err=%b want 0 1 0 0 0",
                     host_controller, cmd_ready, busy, done, err);
        end
    endtask

    task automatic test_init_seq();
        cmd_q = '{mk(4'd1, 12'h0, 48'hABC), mk(4'd2, 12'h003, 48'h123), mk(4'd5, 12'h0, 48'h0)};
        run_program("init_seq");
    endtask

    task automatic test_run_then_init();
        cmd_q = '{mk(4'd3, 12'h03F, 48'd3), mk(4'd1, 12'h0, 48'h5A5A), mk(4'd5, 12'h0, 48'h0)};
        run_program("run_then_init");
    endtask

    task automatic test_bad_opcode();
        cmd_q = '{mk(4'hF, 12'hFFF, 48'hFFFF_FFFF_FFFF), mk(4'd3, 12'h03F, 48'hFFFF_FFFF_0000), mk(4'd5, 12'h0, 48'h0)};
        run_program("bad_opcode");
    endtask

    task automatic test_backpressure();
        logic [47:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = 48'h1000 + 48'(i);
        for (int i = 0; i < 4; i++) push_word(mk(4'd1, 12'h0, p[i]));
        cmd_valid = 1'b1;
        cmd_data  = mk(4'd1, 12'h0, p[4]);
        step();
        step();
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full cmd_ready got %b want 0", cmd_ready);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_exec cmd_ready got %b want 0", cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) cmd_valid = 1'b0;
            n_checks++;
            if (host_controller !== hc_init_spm(p[i])) begin
                n_fail++;
                $display("FAIL bp_word %0d host_controller got %h want %h", i, host_controller, hc_init_spm(p[i]));
            end
        end
        step();
        n_checks++;
        if (host_controller !== 60'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall got hc=%h busy=%b want 0 1", host_controller, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        logic done_before;
        push_word(mk(4'd3, 12'h02A, 48'd10));
        push_word(mk(4'd1, 12'h0, 48'h77));
        push_word(mk(4'd1, 12'h0, 48'h88));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (host_controller !== hc_run(1'b1, 5'b01010)) begin
                n_fail++;
                $display("FAIL abort_run cycle %0d got %h want %h", i, host_controller, hc_run(1'b1, 5'b01010));
            end
        end
        done_before = done;
        abort       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_data    = mk(4'd1, 12'h0, 48'h99);
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        n_checks++;
        if (host_controller !== 60'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== done_before) begin
            n_fail++;
            $display("FAIL abort_after got hc=%h busy=%b ready=%b done=%b want 0 0 1 %b",
                     host_controller, busy, cmd_ready, done, done_before);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (host_controller !== 60'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_flushed got hc=%h busy=%b want 0 1", host_controller, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        push_word(mk(4'd3, 12'h03F, 48'd8));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (host_controller !== hc_run(1'b1, 5'h1F)) begin
            n_fail++;
            $display("FAIL rst_run_active got %h want %h", host_controller, hc_run(1'b1, 5'h1F));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (host_controller !== 60'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run got hc=%h busy=%b ready=%b done=%b err=%b want 0 0 1 0 0",
                     host_controller, busy, cmd_ready, done, err);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [3:0]  op;
        logic [47:0] pl;
        string       nm;
        for (int prog = 0; prog < 4; prog++) begin
            cmd_q.delete();
            for (int i = 0; i < 10; i++) begin
                r = int'($urandom_range(0, 5));
                op = (r == 5) ? 4'($urandom_range(6, 15)) : 4'(r);
                if (op == 4'd3 || op == 4'd4)
                    pl = {$urandom(), 16'($urandom_range(0, 4))};
                else
                    pl = {16'($urandom()), $urandom()};
                cmd_q.push_back(mk(op, 12'($urandom()), pl));
            end
            cmd_q.push_back(mk(4'd5, 12'h0, 48'h0));
            nm = $sformatf("random%0d", prog);
            run_program(nm);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 64'b0;
        test_reset();
        test_init_seq();
        test_run_then_init();
        test_backpressure();
        test_abort();
        test_bad_opcode();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_cfg_sequencer.md
Name: host_cfg_sequencer

Overview:
Host-side issuer for the accelerator's `host_controller` command bus. It is the transmitting end of the 60-bit word the top level decodes:
- bit 59: `run_SPM`
- bits 58:54: `run_PE_array`
- bit 53: `init_SPM`
- bits 52:48: `init_PE_array`
- bits 47:0: instruction

It accepts 64-bit command words over a valid/ready stream, buffers them, and sequences them into cycle-exact init pulses, timed run windows and waits. It sits between the system loader/DMA and the compute top.

Parameters:
- FIFO_DEPTH, 4, command buffer entries (power of two, ≥2)
- CNT_W, 16, width of the RUN/WAIT cycle counter
- H_C_W, 60, width of `host_controller` (held in the shared package)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins execution from IDLE
- abort  in  1  pulse; flushes buffer and returns to IDLE
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  buffer can accept; equals !full
- cmd_data  in  64  {opcode[63:60], aux[59:48], payload[47:0]}
- host_controller  out  H_C_W  registered command bus to the compute top
- busy  out  1  high in EXEC/RUN/WAIT
- done  out  1  sticky; END executed
- err  out  1  sticky; unknown opcode seen

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - state=IDLE, FIFO emptied.
  - host_controller=0, busy=0, done=0, err=0.
  - cmd_ready=1 from the first cycle after reset.
- Push: a word is accepted on a clk edge with cmd_valid&&cmd_ready. Simultaneous push and pop on a full FIFO is not permitted; cmd_ready stays low while full.
- IDLE:
  - FIFO still accepts pushes.
  - host_controller=0.
  - start → EXEC next cycle; start also clears done and err.
- EXEC, FIFO empty: stall with host_controller=0 (no error).
- EXEC, FIFO non-empty: pop the head and decode it. The resulting fields are registered onto host_controller on the same edge, i.e. visible the cycle after the pop.
- Opcodes:
  - 0 NOP: host_controller=0 for one cycle.
  - 1 INIT_SPM: init_SPM=1, instruction=payload for exactly one cycle.
  - 2 INIT_PE: init_PE_array=aux[4:0], instruction=payload for exactly one cycle.
  - 3 RUN:
    - run_SPM=aux[5] and run_PE_array=aux[4:0], instruction=0.
    - Held for exactly N=payload[CNT_W-1:0] cycles; state RUN, counter loaded with N-1.
    - N=0 behaves as NOP.
  - 4 WAIT: host_controller=0 for N=payload[CNT_W-1:0] cycles; state WAIT. N=0 behaves as NOP.
  - 5 END: host_controller=0, done=1, state → IDLE.
  - 6–15: treated as NOP and set err=1.
- Throughput:
  - One-cycle ops issue back-to-back, one per cycle, with no bubble.
  - In the last RUN/WAIT cycle (counter==0), the next command may pop, so its fields appear the cycle immediately after the final window cycle.
- Only one of init_*/run_* groups is ever driven by a single command. Fields not written by the current command are 0.
- abort (any state, takes priority over start/pop):
  - Next cycle: state=IDLE, FIFO flushed, host_controller=0.
  - done and err unchanged.
  - A push on the abort cycle is discarded.
- rst mid-RUN: run bits drop to 0 on the next cycle; no partial state is kept.
- Counter arithmetic is unsigned CNT_W bits. Payload bits above CNT_W are ignored.

Decomposition:
- Shared package:
  - H_C_W=60 and field offsets RUN_SPM_B=59, RUN_PE_HI/LO=58/54, INIT_SPM_B=53, INIT_PE_HI/LO=52/48, PE_inst=48.
  - Opcode constants OP_NOP..OP_END.
  - State encoding IDLE/EXEC/RUN/WAIT.
- One sub-module: cfg_cmd_fifo. Synchronous FIFO, DEPTH/WIDTH params, push/pop/full/empty/flush, show-ahead head output.

Test Plan:
- Reset, then 3 cycles idle → host_controller==0, cmd_ready==1, busy==0, done==0.
- Preload INIT_SPM(payload=48'hABC), INIT_PE(aux=5'b00011, payload=48'h123), END; start → consecutive cycles show {init_SPM=1, instr=48'hABC}, then {init_PE_array=5'b00011, instr=48'h123}, then 0 with done=1.
- RUN(aux=6'b111111, N=3) then INIT_SPM → run_SPM=1 and run_PE_array=5'b11111 for exactly 3 cycles, with init_SPM=1 on the 4th cycle and no gap.
- Push 5 words with no start and FIFO_DEPTH=4 → cmd_ready low after the 4th; the 5th is held until the first pop after start.
- RUN(N=10), abort on run cycle 4 → host_controller==0 from the next cycle, busy=0, FIFO empty, cmd_ready=1.
- Opcode 4'hF, then RUN(N=0), then END → err=1, no run bits ever asserted, done=1.
